fir_mac_engine: RTL and testbench

- Compute stage directly downstream of the AXI-Stream-to-BRAM sample writer.
- After each new sample lands in the data BRAM, this block reads the last TAP_NUM samples plus the coefficients from the tap BRAM, runs one multiply-accumulate per cycle, and emits y[n] on an AXI-Stream master.
- The BRAM data has 1-cycle read latency. There is one output per input sample.

---
 rtl/fir_pkg.sv | 23 ++
 rtl/fir_circ_addr.sv | 28 ++
 rtl/fir_mac_engine.sv | 153 +++++++++++++++
 tb/tb_fir_mac_engine.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared types and defaults for the FIR compute slice.
//   state_t        - FSM encoding of the MAC engine (IDLE, READ, DRAIN, OUT)
//   DATA_WIDTH_DEF - default width of samples, taps, accumulator and result
//   TAP_NUM_DEF    - default number of taps (also circular sample buffer depth)
//   addr_width()   - word-address width needed to index a TAP_NUM-deep BRAM
package fir_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int TAP_NUM_DEF    = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    // A single-entry buffer still needs one address bit.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_circ_addr.sv
// fir_circ_addr: circular-buffer address of sample x[n-k].
//   head - address of the newest sample x[n] (must be < TAP_NUM)
//   k    - tap index / age of the wanted sample (must be < TAP_NUM)
//   addr - (head - k) mod TAP_NUM
// Purely combinational; shared with the sample writer side.
module fir_circ_addr
    import fir_pkg::*;
#(
    parameter int TAP_NUM    = TAP_NUM_DEF,
    parameter int ADDR_WIDTH = addr_width(TAP_NUM)
) (
    input  logic [ADDR_WIDTH-1:0] head,
    input  logic [ADDR_WIDTH-1:0] k,
    output logic [ADDR_WIDTH-1:0] addr
);

    // The buffer depth is generally not a power of two, so the wrap adds
    // TAP_NUM explicitly. The true result is below TAP_NUM, so computing it
    // modulo 2^ADDR_WIDTH loses nothing.
    always_comb begin
        if (head < k) begin
            addr = head - k + ADDR_WIDTH'(TAP_NUM);
        end else begin
            addr = head - k;
        end
    end

endmodule

// File: rtl/fir_mac_engine.sv
// fir_mac_engine: one FIR output per input sample, one MAC per cycle.
//   clk, rst          - single clock, synchronous active-high reset
//   in_smp_valid      - pulse: new sample written at in_smp_head
//   out_smp_ready     - engine idle and able to take a trigger
//   in_smp_head       - data-BRAM address of newest sample x[n]
//   in_smp_last       - newest sample carried tlast
//   out_d_A/out_d_EN  - data BRAM read port, in_d_Do valid one cycle later
//   out_t_A/out_t_EN  - tap BRAM read port, in_t_Do valid one cycle later
//   out_m_*           - AXI-Stream master carrying y[n] and its tlast
//   dbg_state         - current FSM state, for observation only
//
// Handshakes: the sample trigger is taken only in a cycle where both
// in_smp_valid and out_smp_ready are high (a trigger while busy is dropped);
// a result beat transfers on a cycle where out_m_tvalid and in_m_tready are
// both high, and tdata/tlast stay stable until that transfer.
module fir_mac_engine
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int TAP_NUM    = TAP_NUM_DEF,
    parameter int ADDR_WIDTH = addr_width(TAP_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_smp_valid,
    output logic                  out_smp_ready,
    input  logic [ADDR_WIDTH-1:0] in_smp_head,
    input  logic                  in_smp_last,
    output logic [ADDR_WIDTH-1:0] out_d_A,
    output logic                  out_d_EN,
    input  logic [DATA_WIDTH-1:0] in_d_Do,
    output logic [ADDR_WIDTH-1:0] out_t_A,
    output logic                  out_t_EN,
    input  logic [DATA_WIDTH-1:0] in_t_Do,
    output logic                  out_m_tvalid,
    input  logic                  in_m_tready,
    output logic [DATA_WIDTH-1:0] out_m_tdata,
    output logic                  out_m_tlast,
    output state_t                dbg_state
);

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] k_q;
    logic [ADDR_WIDTH-1:0] head_q;
    logic                  last_q;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [ADDR_WIDTH-1:0] circ_addr;
    logic [DATA_WIDTH-1:0] prod;
    logic                  last_k;

    fir_circ_addr #(
        .TAP_NUM    (TAP_NUM),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_circ_addr (
        .head (head_q),
        .k    (k_q),
        .addr (circ_addr)
    );

    // The low DATA_WIDTH bits of a product are identical for signed and
    // unsigned operands, so a same-width multiply gives the truncated
    // two's-complement product directly.
    assign prod   = in_d_Do * in_t_Do;
    assign last_k = (k_q == ADDR_WIDTH'(TAP_NUM - 1));

    assign dbg_state = state_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_smp_valid) state_d = READ;
            READ:    if (last_k)       state_d = DRAIN;
            DRAIN:                     state_d = OUT;
            OUT:     if (in_m_tready)  state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the registered state only; tdata is gated so
    // the bus is quiet (zero) except while a result is being offered.
    always_comb begin
        out_smp_ready = 1'b0;
        out_d_A       = '0;
        out_d_EN      = 1'b0;
        out_t_A       = '0;
        out_t_EN      = 1'b0;
        out_m_tvalid  = 1'b0;
        out_m_tdata   = '0;
        out_m_tlast   = 1'b0;
        case (state_q)
            IDLE: begin
                out_smp_ready = 1'b1;
            end
            READ: begin
                out_d_A  = circ_addr;
                out_d_EN = 1'b1;
                out_t_A  = k_q;
                out_t_EN = 1'b1;
            end
            OUT: begin
                out_m_tvalid = 1'b1;
                out_m_tdata  = acc_q;
                out_m_tlast  = last_q;
            end
            default: ;
        endcase
    end

    // Tap counter, captured trigger fields and accumulator. Read data always
    // belongs to the pair issued one cycle earlier, so accumulation starts on
    // the second READ cycle and the final pair lands in DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q    <= '0;
            head_q <= '0;
            last_q <= 1'b0;
            acc_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_smp_valid) begin
                        head_q <= in_smp_head;
                        last_q <= in_smp_last;
                        acc_q  <= '0;
                        k_q    <= '0;
                    end
                end
                READ: begin
                    k_q <= last_k ? '0 : k_q + ADDR_WIDTH'(1);
                    if (k_q != '0) begin
                        acc_q <= acc_q + prod;
                    end
                end
                DRAIN: begin
                    acc_q <= acc_q + prod;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_engine.sv
// tb_fir_mac_engine: directed, table-driven bench for fir_mac_engine with
// behavioural 1-cycle-latency data and tap BRAMs.
module tb_fir_mac_engine;
    import fir_pkg::*;

    localparam int DW = 32;
    localparam int TN = 11;
    localparam int AW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          in_smp_valid = 1'b0;
    logic          out_smp_ready;
    logic [AW-1:0] in_smp_head = '0;
    logic          in_smp_last = 1'b0;
    logic [AW-1:0] out_d_A;
    logic          out_d_EN;
    logic [DW-1:0] in_d_Do;
    logic [AW-1:0] out_t_A;
    logic          out_t_EN;
    logic [DW-1:0] in_t_Do;
    logic          out_m_tvalid;
    logic          in_m_tready = 1'b1;
    logic [DW-1:0] out_m_tdata;
    logic          out_m_tlast;
    state_t        dbg_state;

    fir_mac_engine dut (
        .clk           (clk),
        .rst           (rst),
        .in_smp_valid  (in_smp_valid),
        .out_smp_ready (out_smp_ready),
        .in_smp_head   (in_smp_head),
        .in_smp_last   (in_smp_last),
        .out_d_A       (out_d_A),
        .out_d_EN      (out_d_EN),
        .in_d_Do       (in_d_Do),
        .out_t_A       (out_t_A),
        .out_t_EN      (out_t_EN),
        .in_t_Do       (in_t_Do),
        .out_m_tvalid  (out_m_tvalid),
        .in_m_tready   (in_m_tready),
        .out_m_tdata   (out_m_tdata),
        .out_m_tlast   (out_m_tlast),
        .dbg_state     (dbg_state)
    );

    // ---------------- BRAM models ----------------
    logic [DW-1:0] data_mem [TN];
    logic [DW-1:0] tap_mem  [TN];

    always @(posedge clk) begin
        if (out_d_EN) in_d_Do <= data_mem[out_d_A];
        if (out_t_EN) in_t_Do <= tap_mem[out_t_A];
    end

    always @(posedge clk) begin
        if (!rst && in_smp_valid)
            assert (in_smp_head < AW'(TN)) else $error("illegal head %0d", in_smp_head);
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic fill_mem(input logic [DW-1:0] tb_, input logic [DW-1:0] ts,
                            input logic [DW-1:0] sb, input logic [DW-1:0] ss);
        for (int i = 0; i < TN; i++) begin
            tap_mem[i]  = tb_ + ts * DW'(i);
            data_mem[i] = sb + ss * DW'(i);
        end
    endtask

    // Trigger in cycle 0, expect tvalid in cycle TN+2 with tready held high.
    task automatic run_one(input string tag, input logic [AW-1:0] head, input logic last,
                           input logic [DW-1:0] exp_data, input bit trace);
        int cyc;
        int exp_a;
        @(negedge clk);
        check({tag, "_ready_before"}, DW'(out_smp_ready), 32'd1);
        in_smp_valid = 1'b1;
        in_smp_head  = head;
        in_smp_last  = last;
        exp_q.push_back(exp_data);
        @(negedge clk);
        in_smp_valid = 1'b0;
        cyc = 1;
        while (!out_m_tvalid && cyc < 40) begin
            if (trace && cyc <= TN) begin
                exp_a = (int'(head) - (cyc - 1) + TN) % TN;
                check({tag, "_d_A"}, DW'(out_d_A), DW'(exp_a));
                check({tag, "_t_A"}, DW'(out_t_A), DW'(cyc - 1));
                check({tag, "_en"}, DW'({out_d_EN, out_t_EN}), 32'd3);
                check({tag, "_ready_busy"}, DW'(out_smp_ready), 32'd0);
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, DW'(cyc), DW'(TN + 2));
        if (out_m_tvalid && exp_q.size() > 0) begin
            check({tag, "_tdata"}, out_m_tdata, exp_q.pop_front());
            check({tag, "_tlast"}, DW'(out_m_tlast), DW'(last));
        end else begin
            exp_q.delete();
        end
        @(negedge clk);
        check({tag, "_tvalid_after"}, DW'(out_m_tvalid), 32'd0);
        check({tag, "_ready_after"}, DW'(out_smp_ready), 32'd1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [DW-1:0] tap_base;
        logic [DW-1:0] tap_step;
        logic [DW-1:0] smp_base;
        logic [DW-1:0] smp_step;
        logic [AW-1:0] head;
        logic          last;
        logic [DW-1:0] exp_data;
        bit            trace;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int cnt;
        // taps all 1, samples 1..11 -> 66 for any head
        vecs[0] = '{32'd1, 32'd0, 32'd1, 32'd1, 4'd10, 1'b0, 32'd66, 1'b1};
        vecs[1] = '{32'd1, 32'd0, 32'd1, 32'd1, 4'd3,  1'b1, 32'd66, 1'b0};
        // taps 1..11, samples all 2 -> 132
        vecs[2] = '{32'd1, 32'd1, 32'd2, 32'd0, 4'd5,  1'b0, 32'd132, 1'b0};
        // 0x7FFFFFFF * 2 truncates to -2; eleven of them -> -22
        vecs[3] = '{32'h7FFF_FFFF, 32'd0, 32'd2, 32'd0, 4'd7, 1'b1, 32'hFFFF_FFEA, 1'b0};
        // taps -1, samples 1..11 -> -66
        vecs[4] = '{32'hFFFF_FFFF, 32'd0, 32'd1, 32'd1, 4'd9, 1'b0, 32'hFFFF_FFBE, 1'b0};
        // taps 1..11, x[i]=i, head 0: 2*10+3*9+...+11*1 = 275; address wraps
        vecs[5] = '{32'd1, 32'd1, 32'd0, 32'd1, 4'd0, 1'b0, 32'd275, 1'b1};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", DW'(dbg_state), DW'(IDLE));
        check("rst_ready", DW'(out_smp_ready), 32'd1);
        check("rst_tvalid", DW'(out_m_tvalid), 32'd0);
        check("rst_tdata", out_m_tdata, 32'd0);
        check("rst_tlast", DW'(out_m_tlast), 32'd0);
        check("rst_en", DW'({out_d_EN, out_t_EN}), 32'd0);
        rst = 1'b0;

        // table-driven vectors
        for (int v = 0; v < 6; v++) begin
            fill_mem(vecs[v].tap_base, vecs[v].tap_step, vecs[v].smp_base, vecs[v].smp_step);
            run_one($sformatf("vec%0d", v), vecs[v].head, vecs[v].last, vecs[v].exp_data, vecs[v].trace);
        end

        // impulse: circular indexing moves the impulse to tap 1
        fill_mem(32'd1, 32'd1, 32'd0, 32'd0);
        data_mem[3] = 32'd1;
        run_one("imp_h3", 4'd3, 1'b0, 32'd1, 1'b0);
        run_one("imp_h4", 4'd4, 1'b1, 32'd2, 1'b0);

        // backpressure: result held 5 cycles, busy trigger dropped
        fill_mem(32'd1, 32'd0, 32'd1, 32'd1);
        in_m_tready = 1'b0;
        @(negedge clk);
        in_smp_valid = 1'b1;
        in_smp_head  = 4'd10;
        in_smp_last  = 1'b1;
        @(negedge clk);
        in_smp_valid = 1'b0;
        cnt = 1;
        while (!out_m_tvalid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("bp_latency", DW'(cnt), DW'(TN + 2));
        for (int i = 0; i < 5; i++) begin
            check("bp_tvalid", DW'(out_m_tvalid), 32'd1);
            check("bp_tdata", out_m_tdata, 32'd66);
            check("bp_tlast", DW'(out_m_tlast), 32'd1);
            check("bp_ready", DW'(out_smp_ready), 32'd0);
            in_smp_valid = (i == 1);
            in_smp_head  = 4'd7;
            @(negedge clk);
        end
        in_smp_valid = 1'b0;
        in_m_tready  = 1'b1;
        @(negedge clk);
        check("bp_tvalid_after", DW'(out_m_tvalid), 32'd0);
        check("bp_state_after", DW'(dbg_state), DW'(IDLE));
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (out_m_tvalid || out_d_EN) cnt++;
            @(negedge clk);
        end
        check("bp_trigger_dropped", DW'(cnt), 32'd0);

        // reset in READ at k=5 aborts with no output beat
        @(negedge clk);
        in_smp_valid = 1'b1;
        in_smp_head  = 4'd10;
        in_smp_last  = 1'b1;
        @(negedge clk);
        in_smp_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_k5", DW'(out_t_A), 32'd5);
        check("mid_state_read", DW'(dbg_state), DW'(READ));
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_state", DW'(dbg_state), DW'(IDLE));
        check("mid_rst_tvalid", DW'(out_m_tvalid), 32'd0);
        check("mid_rst_ready", DW'(out_smp_ready), 32'd1);
        check("mid_rst_tdata", out_m_tdata, 32'd0);
        check("mid_rst_en", DW'({out_d_EN, out_t_EN}), 32'd0);
        rst = 1'b0;
        run_one("post_rst", 4'd6, 1'b0, 32'd66, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
